// File: rtl/alu_pkg.sv
// Shared types for the serial adder, the ripple subtractor and the ALU wrapper:
// FSM state encoding, the NZCV flag bundle and the signed-overflow rule.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Two's-complement overflow: both operands share a sign that the result lacks.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder: the addition twin of the full-subtractor cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first, x+1 cycles
// from start to registered sum and NZCV flags.
//
// Handshake: start is accepted on any rising edge where the unit is not in RUN
// (IDLE or DONE); there is no backpressure, and start/a/b/cin are ignored while
// busy. done is a one-cycle pulse coinciding with the update of s/cout/NZCV.
module serial_add
    import alu_pkg::*;
#(
    parameter int x = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [x-1:0] a,
    input  logic [x-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [x-1:0] s,
    output logic         cout,
    output logic         N,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(x);
    localparam logic [CW-1:0] LAST = CW'(x - 1);

    add_state_t    state;
    add_state_t    state_nx;
    logic [x-1:0]  a_sh;
    logic [x-1:0]  b_sh;
    logic [x-1:0]  sum_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          a_msb;
    logic          b_msb;
    logic          fa_s;
    logic          fa_c;
    logic          accept;
    nzcv_t         flags;

    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept = start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        state_dbg = state;
    end

    // Operand MSBs are kept aside because the shift registers drain to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            a_msb <= a[x-1];
            b_msb <= b[x-1];
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[x-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            flags <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                s       <= sum_sh;
                cout    <= carry;
                flags.n <= sum_sh[x-1];
                flags.z <= (sum_sh == '0);
                flags.c <= carry;
                flags.v <= add_overflow(a_msb, b_msb, sum_sh[x-1]);
            end
        end
    end

    assign N = flags.n;
    assign Z = flags.z;
    assign C = flags.c;
    assign V = flags.v;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: transaction-level model with an expected
// queue, per-cycle compare, directed cases with literal results, random stimulus.
module tb_serial_add;

    localparam int X = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [X-1:0] a_in;
    logic [X-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [X-1:0] s;
    logic         cout;
    logic         N, Z, C, V;
    logic [1:0]   state_dbg;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic        cmp_en  = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    serial_add #(.x(X)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin_in),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .cout      (cout),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // An accepted addition finishes x+1 edges later; cnt_m counts down to that edge.
    logic [X+1:0] exp_q[$];
    int           cnt_m     = 0;
    logic         exp_done  = 1'b0;
    logic [X-1:0] exp_s     = '0;
    logic         exp_cout  = 1'b0;
    logic [3:0]   exp_nzcv  = '0;
    logic         exp_busy;

    assign exp_busy = (cnt_m >= 2);

    always @(posedge clk or negedge rst_n) begin : model_p
        int old, nc, sa, sb, tot;
        logic [X:0]   full;
        logic [X+1:0] ent;
        if (!rst_n) begin
            cnt_m    <= 0;
            exp_done <= 1'b0;
            exp_s    <= '0;
            exp_cout <= 1'b0;
            exp_nzcv <= '0;
            exp_q.delete();
        end else begin
            old = cnt_m;
            nc  = (old > 0) ? old - 1 : 0;
            exp_done <= 1'b0;
            if (old == 1 && exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                exp_s    <= ent[X-1:0];
                exp_cout <= ent[X];
                exp_nzcv <= {ent[X-1], (ent[X-1:0] == '0), ent[X], ent[X+1]};
                exp_done <= 1'b1;
            end
            if (start && old <= 1) begin
                full = {1'b0, a_in} + {1'b0, b_in} + {{X{1'b0}}, cin_in};
                sa = int'(a_in); if (a_in[X-1]) sa -= (1 << X);
                sb = int'(b_in); if (b_in[X-1]) sb -= (1 << X);
                tot = sa + sb + int'(cin_in);
                ent = {(tot > (1 << (X-1)) - 1) || (tot < -(1 << (X-1))), full};
                exp_q.push_back(ent);
                nc = X + 1;
            end
            cnt_m <= nc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("s", s, exp_s);
            chk("cout", cout, exp_cout);
            chk("nzcv", {N, Z, C, V}, exp_nzcv);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 4 * X; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk({name, "_latency"}, lat, X + 1);
    endtask

    task automatic run_op(input string name, input logic [X-1:0] av, input logic [X-1:0] bv,
                          input logic cv, input logic [X-1:0] es, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        start = 1'b1; a_in = av; b_in = bv; cin_in = cv;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = X'($urandom_range(0, (1 << X) - 1));
        b_in = X'($urandom_range(0, (1 << X) - 1));
        cin_in = 1'($urandom_range(0, 1));
        wait_done(name, lat);
        chk({name, "_s"}, s, es);
        chk({name, "_nzcv"}, {N, Z, C, V}, ef);
        chk({name, "_model_s"}, exp_s, es);
        chk({name, "_model_nzcv"}, exp_nzcv, ef);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out", {busy, done, s, cout, N, Z, C, V}, 0);
        rst_n = 1'b1;

        run_op("add_3_4",  4'd3,  4'd4, 1'b0, 4'd7, 4'b0000);
        run_op("add_7_1",  4'd7,  4'd1, 1'b0, 4'd8, 4'b1001);
        run_op("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 4'b0110);
        run_op("add_8_8",  4'd8,  4'd8, 1'b0, 4'd0, 4'b0111);
        run_op("add_cin",  4'd0,  4'd0, 1'b1, 4'd1, 4'b0000);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1; a_in = 4'd2; b_in = 4'd3; cin_in = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a_in = 4'd9; b_in = 4'd9; cin_in = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 4 * X; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("midrun_latency", lat, X + 1);
        chk("midrun_s", s, 5);
        repeat (X + 3) @(negedge clk);
        chk("midrun_no_second_done", done, 0);

        // back-to-back: start held through the DONE cycle
        @(negedge clk);
        start = 1'b1; a_in = 4'd6; b_in = 4'd1; cin_in = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (X) @(posedge clk);
        #1 start = 1'b1; a_in = 4'd12; b_in = 4'd13; cin_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_first_done", done, 1);
        chk("b2b_first_s", s, 7);
        wait_done("b2b_second", lat);
        chk("b2b_second_s", s, 9);
        chk("b2b_second_nzcv", {N, Z, C, V}, 4'b1010);

        // reset during bit 2 aborts the addition
        @(negedge clk);
        start = 1'b1; a_in = 4'd5; b_in = 4'd6; cin_in = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_out", {busy, done, s, cout, N, Z, C, V}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (X + 2) @(negedge clk);
        run_op("after_rst", 4'd5, 4'd6, 1'b0, 4'd11, 4'b1001);

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 2) != 0);
            a_in   = X'($urandom_range(0, (1 << X) - 1));
            b_in   = X'($urandom_range(0, (1 << X) - 1));
            cin_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2 * X + 4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
